// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter (ALU vs LSU) with a per-register busy scoreboard for RAW stalls.
// Define REGFILE_WB_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module regfile_wb_arbiter #(
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid_ip,
  input  logic [4:0]    alu_addr_ip,
  input  logic [XW-1:0] alu_data_ip,
  output logic          alu_ready_op,
  input  logic          lsu_valid_ip,
  input  logic [4:0]    lsu_addr_ip,
  input  logic [XW-1:0] lsu_data_ip,
  output logic          lsu_ready_op,
  input  logic          issue_en_ip,
  input  logic [4:0]    issue_addr_ip,
  input  logic          flush_ip,
  input  logic [4:0]    chk_addr1_ip,
  input  logic [4:0]    chk_addr2_ip,
  output logic          hazard_op,
  output logic [31:0]   busy_op,
  output logic          wr_en_op,
  output logic [4:0]    wr_addr_op,
  output logic [XW-1:0] wr_data_op
);

  logic          alu_gnt, lsu_gnt, acc;
  logic [4:0]    acc_addr;
  logic [XW-1:0] acc_data;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [XW-1:0] wr_data_q, wr_data_d;
  logic [31:0]   busy_q, busy_d;

`ifdef REGFILE_WB_ARB_RR_EN
  // Pointer names the preferred requester (1 = LSU) and toggles on every accept.
  logic pref_lsu_q, pref_lsu_d;

  assign alu_gnt    = alu_valid_ip && (!lsu_valid_ip || !pref_lsu_q);
  assign lsu_gnt    = lsu_valid_ip && (!alu_valid_ip ||  pref_lsu_q);
  assign pref_lsu_d = acc ? !pref_lsu_q : pref_lsu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pref_lsu_q <= 1'b0;
    else     pref_lsu_q <= pref_lsu_d;
  end
`else
  assign lsu_gnt = lsu_valid_ip;
  assign alu_gnt = alu_valid_ip && !lsu_valid_ip;
`endif

  assign alu_ready_op = alu_gnt;
  assign lsu_ready_op = lsu_gnt;
  assign acc          = alu_gnt || lsu_gnt;
  assign acc_addr     = lsu_gnt ? lsu_addr_ip : alu_addr_ip;
  assign acc_data     = lsu_gnt ? lsu_data_ip : alu_data_ip;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_en_d   = acc && (acc_addr != 5'd0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (acc) begin
      wr_addr_d = acc_addr;
      wr_data_d = acc_data;
    end

    // Retire clears first so a same-edge issue to that register wins; flush overrides both.
    busy_d = busy_q;
    if (wr_en_q)     busy_d[wr_addr_q]     = 1'b0;
    if (issue_en_ip) busy_d[issue_addr_ip] = 1'b1;
    if (flush_ip)    busy_d                = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is 32 flops, not a RAM, so it is reset directly; no init sweep needed.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign hazard_op  = busy_q[chk_addr1_ip] || busy_q[chk_addr2_ip];
  assign busy_op    = busy_q;
  assign wr_en_op   = wr_en_q;
  assign wr_addr_op = wr_addr_q;
  assign wr_data_op = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural scoreboard/arbitration model.
module tb_regfile_wb_arbiter;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid_ip = 1'b0, lsu_valid_ip = 1'b0;
  logic [4:0]    alu_addr_ip = '0, lsu_addr_ip = '0;
  logic [XW-1:0] alu_data_ip = '0, lsu_data_ip = '0;
  logic          alu_ready_op, lsu_ready_op;
  logic          issue_en_ip = 1'b0, flush_ip = 1'b0;
  logic [4:0]    issue_addr_ip = '0, chk_addr1_ip = '0, chk_addr2_ip = '0;
  logic          hazard_op, wr_en_op;
  logic [31:0]   busy_op;
  logic [4:0]    wr_addr_op;
  logic [XW-1:0] wr_data_op;

  regfile_wb_arbiter #(.XW(XW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_ip(alu_valid_ip), .alu_addr_ip(alu_addr_ip), .alu_data_ip(alu_data_ip),
    .alu_ready_op(alu_ready_op),
    .lsu_valid_ip(lsu_valid_ip), .lsu_addr_ip(lsu_addr_ip), .lsu_data_ip(lsu_data_ip),
    .lsu_ready_op(lsu_ready_op),
    .issue_en_ip(issue_en_ip), .issue_addr_ip(issue_addr_ip), .flush_ip(flush_ip),
    .chk_addr1_ip(chk_addr1_ip), .chk_addr2_ip(chk_addr2_ip),
    .hazard_op(hazard_op), .busy_op(busy_op),
    .wr_en_op(wr_en_op), .wr_addr_op(wr_addr_op), .wr_data_op(wr_data_op)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of busy registers, one pending regfile write, arbitration preference.
  typedef struct {
    bit            en;
    logic [4:0]    addr;
    logic [XW-1:0] data;
  } wr_t;

  bit  busy_m [32];
  wr_t wr_m;
  bit  pref_lsu_m;
  bit  g_alu, g_lsu;

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    wr_m       = '{en: 1'b0, addr: '0, data: '0};
    pref_lsu_m = 1'b0;
    g_alu      = 1'b0;
    g_lsu      = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [31:0] exp_busy;
    logic [4:0]  a;
    bit          lsu_wins;
    @(negedge clk);
    if (alu_valid_ip && lsu_valid_ip) begin
`ifdef REGFILE_WB_ARB_RR_EN
      lsu_wins = pref_lsu_m;
`else
      lsu_wins = 1'b1;
`endif
      g_lsu = lsu_wins;
      g_alu = !lsu_wins;
    end else begin
      g_alu = alu_valid_ip;
      g_lsu = lsu_valid_ip;
    end
    for (int i = 0; i < 32; i++) exp_busy[i] = busy_m[i];
    check("alu_ready", alu_ready_op, g_alu);
    check("lsu_ready", lsu_ready_op, g_lsu);
    check("busy", busy_op, exp_busy);
    check("hazard", hazard_op, busy_m[chk_addr1_ip] || busy_m[chk_addr2_ip]);
    check("wr_en", wr_en_op, wr_m.en);
    if (wr_m.en) begin
      check("wr_addr", wr_addr_op, wr_m.addr);
      check("wr_data", wr_data_op, wr_m.data);
    end
    @(posedge clk);
    if (wr_m.en) busy_m[wr_m.addr] = 1'b0;
    if (issue_en_ip && issue_addr_ip != 0) busy_m[issue_addr_ip] = 1'b1;
    if (flush_ip) foreach (busy_m[i]) busy_m[i] = 1'b0;
    if (g_alu || g_lsu) begin
      a          = g_lsu ? lsu_addr_ip : alu_addr_ip;
      wr_m.en    = (a != 0);
      wr_m.addr  = a;
      wr_m.data  = g_lsu ? lsu_data_ip : alu_data_ip;
      pref_lsu_m = !pref_lsu_m;
    end else begin
      wr_m.en = 1'b0;
    end
    #1;
  endtask

  task automatic drop_granted();
    if (g_alu) alu_valid_ip = 1'b0;
    if (g_lsu) lsu_valid_ip = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    alu_valid_ip = 1'b0;
    lsu_valid_ip = 1'b0;
    issue_en_ip  = 1'b0;
    flush_ip     = 1'b0;
    #1;
    check("rst_wr_en", wr_en_op, 0);
    check("rst_wr_addr", wr_addr_op, 0);
    check("rst_wr_data", wr_data_op, 0);
    check("rst_busy", busy_op, 0);
    check("rst_alu_ready", alu_ready_op, 0);
    check("rst_lsu_ready", lsu_ready_op, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_wr_en", wr_en_op, 0);
    rst = 1'b0;
  endtask

  initial begin
    int alu_left, lsu_left;
    model_reset();
    #1;
    do_reset();

    // Reset while an accepted write sits in the output register drops it.
    issue_en_ip = 1'b1; issue_addr_ip = 5'd3;
    step();
    issue_en_ip = 1'b0;
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd3; alu_data_ip = 32'hA5A5_0003;
    step();
    check("pre_rst_wr_en", wr_en_op, 1);
    do_reset();
    step();

    // Single write: issue x5, write it in cycle 3, busy clears two cycles later.
    issue_en_ip = 1'b1; issue_addr_ip = 5'd5; chk_addr1_ip = 5'd5; chk_addr2_ip = 5'd0;
    step();
    issue_en_ip = 1'b0;
    check("sw_busy5", busy_op[5], 1);
    check("sw_hazard", hazard_op, 1);
    step(); step();
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd5; alu_data_ip = 32'hDEAD_BEEF;
    step();
    alu_valid_ip = 1'b0;
    check("sw_wr_en", wr_en_op, 1);
    check("sw_wr_addr", wr_addr_op, 5);
    check("sw_wr_data", wr_data_op, 32'hDEAD_BEEF);
    step();
    check("sw_busy5_clr", busy_op[5], 0);
    check("sw_hazard_clr", hazard_op, 0);

    // Contention: both valid, loser holds until granted.
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd1; alu_data_ip = 32'h11;
    lsu_valid_ip = 1'b1; lsu_addr_ip = 5'd2; lsu_data_ip = 32'h22;
    step(); drop_granted();
`ifndef REGFILE_WB_ARB_RR_EN
    check("cont_first_data", wr_data_op, 32'h22);
`endif
    step(); drop_granted();
`ifndef REGFILE_WB_ARB_RR_EN
    check("cont_second_data", wr_data_op, 32'h11);
`endif
    step();

    // Continuous contention for four requests each.
    alu_left = 4; lsu_left = 4;
    alu_valid_ip = 1'b1; lsu_valid_ip = 1'b1;
    for (int c = 0; c < 12 && (alu_left + lsu_left) > 0; c++) begin
      alu_addr_ip = 5'(8 + alu_left);  alu_data_ip = 32'hA000 + XW'(alu_left);
      lsu_addr_ip = 5'(16 + lsu_left); lsu_data_ip = 32'hB000 + XW'(lsu_left);
      step();
      if (g_alu) alu_left--;
      if (g_lsu) lsu_left--;
      alu_valid_ip = (alu_left > 0);
      lsu_valid_ip = (lsu_left > 0);
    end
    check("cont4_done", alu_left + lsu_left, 0);
    step();

    // Write to x0: acknowledged, no regfile write.
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd0; alu_data_ip = 32'hFFFF_FFFF;
    step();
    alu_valid_ip = 1'b0;
    check("x0_no_write", wr_en_op, 0);

    // Set and clear of x7 on the same edge: set wins.
    issue_en_ip = 1'b1; issue_addr_ip = 5'd7;
    step();
    issue_en_ip = 1'b0;
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd7; alu_data_ip = 32'h77;
    step();
    alu_valid_ip = 1'b0;
    issue_en_ip = 1'b1; issue_addr_ip = 5'd7;
    step();
    issue_en_ip = 1'b0;
    check("collide_busy7", busy_op[7], 1);

    // Flush with concurrent accept and issue.
    foreach (busy_m[i]) if (i == 3 || i == 9 || i == 12) begin
      issue_en_ip = 1'b1; issue_addr_ip = 5'(i);
      step();
    end
    flush_ip = 1'b1; issue_addr_ip = 5'd20;
    alu_valid_ip = 1'b1; alu_addr_ip = 5'd4; alu_data_ip = 32'h44;
    step();
    flush_ip = 1'b0; issue_en_ip = 1'b0; alu_valid_ip = 1'b0;
    check("flush_busy", busy_op, 0);
    check("flush_wr_en", wr_en_op, 1);
    check("flush_wr_data", wr_data_op, 32'h44);
    step();

    // Randomized traffic; requesters obey the hold-until-ready rule.
    for (int c = 0; c < 600; c++) begin
      if (!alu_valid_ip || g_alu) begin
        alu_valid_ip = ($urandom_range(0, 2) != 0);
        alu_addr_ip  = 5'($urandom_range(0, 9));
        alu_data_ip  = $urandom;
      end
      if (!lsu_valid_ip || g_lsu) begin
        lsu_valid_ip = ($urandom_range(0, 3) == 0);
        lsu_addr_ip  = 5'($urandom_range(0, 9));
        lsu_data_ip  = $urandom;
      end
      issue_en_ip   = ($urandom_range(0, 2) == 0);
      issue_addr_ip = 5'($urandom_range(0, 9));
      flush_ip      = ($urandom_range(0, 39) == 0);
      chk_addr1_ip  = 5'($urandom_range(0, 9));
      chk_addr2_ip  = 5'($urandom);
      step();
    end
    alu_valid_ip = 1'b0; lsu_valid_ip = 1'b0; issue_en_ip = 1'b0; flush_ip = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
